// File: rtl/control_contador_pkg.sv
// control_contador_pkg
//   Shared definitions for the counter control stage:
//   - FSM state encoding (IDLE=0, RUN=1, CLEAR=2), kept at the legacy values.
//   - Board and simulation defaults for the debounce length and tick divider.
package control_contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Board values assume a 50 MHz clock: 10 ms debounce, 2 Hz count rate.
  localparam int unsigned DEB_CYCLES_BOARD = 500_000;
  localparam int unsigned TICK_DIV_BOARD   = 25_000_000;

  // Short values so the behaviour is observable in simulation.
  localparam int unsigned DEB_CYCLES_SIM   = 4;
  localparam int unsigned TICK_DIV_SIM     = 5;

endpackage

// File: rtl/boton_antirrebote.sv
// boton_antirrebote
//   Conditions one raw push-button: 2-FF synchronizer, counter-based
//   debounce and a one-cycle pulse on the debounced rising edge.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   btn    in   raw asynchronous button, active-high
//   pulse  out  one-cycle press pulse (registered sources only)
module boton_antirrebote
  import control_contador_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic          sync;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] cnt;

  assign sync = sync_ff[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_ff <= {sync_ff[0], btn};
      deb_d   <= deb;
      // The level only moves after DEB_CYCLES consecutive disagreeing samples;
      // any agreeing sample restarts the count.
      if (sync != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = deb & ~deb_d;

endmodule

// File: rtl/control_contador.sv
// control_contador
//   Control stage for the 4-bit enable/clear counter. Debounces the run/stop
//   and clear buttons and drives the counter's EN and CLR. While running, EN
//   is a one-cycle tick every TICK_DIV cycles; a clear is a single EN=1/CLR=1
//   cycle since the counter only honours CLR together with EN.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   btn_run  in   raw run/stop toggle button
//   btn_clr  in   raw clear button
//   EN       out  counter enable
//   CLR      out  counter clear
//   running  out  1 while counting, or clearing with RUN as return target
module control_contador
  import control_contador_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_SIM,
  parameter int unsigned TICK_DIV   = TICK_DIV_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clr,
  output logic EN,
  output logic CLR,
  output logic running
);

  localparam int unsigned DW = $clog2(TICK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic          run_press;
  logic          clr_press;
  state_t        state;
  logic          ret_run;
  logic [DW-1:0] div;

  boton_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_run (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_run),
    .pulse (run_press)
  );

  boton_antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .pulse (clr_press)
  );

  // Clear has priority over run when both presses land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ret_run <= 1'b0;
      div     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_press) begin
            state   <= CLEAR;
            ret_run <= 1'b0;
          end else if (run_press) begin
            state <= RUN;
            div   <= '0;
          end
        end
        RUN: begin
          div <= (div == DIV_LAST) ? '0 : div + 1'b1;
          if (clr_press) begin
            state   <= CLEAR;
            ret_run <= 1'b1;
          end else if (run_press) begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          // Presses during this cycle are dropped; divider phase restarts.
          state <= ret_run ? RUN : IDLE;
          div   <= '0;
        end
        default: begin
          state <= IDLE;
          div   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, never the button inputs.
  always_comb begin
    EN      = 1'b0;
    CLR     = 1'b0;
    running = 1'b0;
    case (state)
      RUN: begin
        EN      = (div == DIV_LAST);
        running = 1'b1;
      end
      CLEAR: begin
        EN      = 1'b1;
        CLR     = 1'b1;
        running = ret_run;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_contador.md
Name: control_contador

Overview:
Upstream control stage for the 4-bit enable/clear counter. It conditions two raw push-buttons (run/stop toggle, clear) and produces the counter's EN and CLR inputs. EN is a periodic one-cycle tick while running, so counting is visible at board rate. Clear is issued as a one-cycle EN=1/CLR=1 pair, because the counter only honours CLR when EN=1.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=1)
TICK_DIV, 5, clock cycles per EN tick while running (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
btn_run  input  1  raw run/stop button, asynchronous, active-high
btn_clr  input  1  raw clear button, asynchronous, active-high
EN  output  1  counter enable, drives counter EN
CLR  output  1  counter clear, drives counter CLR
running  output  1  status: 1 when counting (or clearing with RUN as return target)

Behaviour:
- Single clock clk; rst is synchronous and active-high. All flops take their reset value on the clk edge where rst=1.
- Reset values: EN=0, CLR=0, running=0; state=IDLE; return flag=0; sync flops, debounced levels, debounce counters and divider all 0.
- Per-button conditioning chain:
  - 2-FF synchronizer.
  - Debounce: at each edge, if sync!=deb then: when cnt==DEB_CYCLES-1, deb<=sync and cnt<=0; otherwise cnt<=cnt+1. If sync==deb, cnt<=0.
  - Press pulse = deb & ~deb_d, where deb_d is deb delayed one cycle.
- Latency: button first sampled high at edge 1 -> deb=1 after edge 2+DEB_CYCLES -> FSM acts at edge 3+DEB_CYCLES.
- FSM states IDLE, RUN, CLEAR (2-bit, registered):
  - IDLE: EN=0, CLR=0. run press -> RUN with div<=0. clr press -> CLEAR with ret<=IDLE.
  - RUN: div counts 0..TICK_DIV-1 and wraps. EN=1, CLR=0 only while div==TICK_DIV-1. run press -> IDLE. clr press -> CLEAR with ret<=RUN.
  - CLEAR: EN=1 and CLR=1 for exactly one cycle, then go to ret with div<=0.
- EN/CLR are decoded from state and div registers only; no combinational path from the btn_* inputs.
- First EN tick after entering RUN at edge t is high during the cycle after edge t+TICK_DIV-1 (consumed by the counter at edge t+TICK_DIV).
- Simultaneous run and clr presses in the same cycle: clr wins and the run press is discarded.
- Presses arriving during the CLEAR cycle are ignored.
- Leaving RUN mid-period discards the divider phase; re-entry always restarts at div=0.
- running = (state==RUN) | (state==CLEAR & ret==RUN).
- Reset mid-operation: immediate return to IDLE. A button held through reset is seen as a fresh press once the debounce latency elapses after rst falls.
- Widths: debounce counter $clog2(DEB_CYCLES)+1 bits; divider $clog2(TICK_DIV)+1 bits; both compare against param-1 exactly.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, CLEAR=2'd2;
  - defaults for DEB_CYCLES and TICK_DIV (board values plus simulation values).
- One sub-module, boton_antirrebote (synchronizer + debounce + rising-edge pulse, parameter DEB_CYCLES), instantiated twice.
- The FSM and divider live in the top module.

Test Plan:
1. rst=1 for 3 cycles, buttons low -> EN=0, CLR=0, running=0 throughout, and for 20 cycles after rst falls.
2. btn_run high from edge 1 for 10 cycles (DEB_CYCLES=4, TICK_DIV=5) -> running=1 after edge 7; EN high only in the cycles after edges 11, 16, 21; CLR=0.
3. btn_run toggled every 2 cycles for 12 cycles, then low -> no press, running stays 0, EN never asserted.
4. While RUN, clean btn_clr press -> exactly one cycle EN=1, CLR=1; running stays 1; next EN tick 5 cycles after CLEAR. Repeated from IDLE -> one EN=CLR=1 cycle, then EN=0 indefinitely.
5. btn_run and btn_clr rise in the same cycle from IDLE -> single CLEAR cycle, return to IDLE, running=0. Second clean btn_run press in RUN -> IDLE, EN=0 thereafter.
6. rst pulsed 1 cycle mid-RUN with btn_run held high -> EN=0, running=0 after that edge; running rises again DEB_CYCLES+3 edges after rst falls, then EN ticks resume.
